// File: rtl/reduction_mux_pipe.sv
// rtl/reduction_mux_pipe.sv - registered per-lane group select stage with runtime config and out-of-range counter
module reduction_mux_pipe #(
  parameter int W       = 32,
  parameter int NUM_IN  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cfg_valid,
  input  logic [NUM_OUT*SEL_W-1:0] i_cfg_sel,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NUM_IN*W-1:0]      i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NUM_OUT*W-1:0]     o_data,
  input  logic                     i_clr_cnt,
  output logic [CNT_W-1:0]         o_oor_cnt
);

  localparam int               GRP     = NUM_IN / NUM_OUT;
  localparam logic [SEL_W-1:0] GRP_SEL = SEL_W'(GRP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_OUT*SEL_W-1:0] sel_q;
  logic [NUM_OUT*W-1:0]     lane_data;
  logic [NUM_OUT-1:0]       lane_oor;
  logic                     accept;
  logic                     any_oor;

  // A new beat may enter whenever the output register is empty or being drained this cycle.
  assign o_ready = ~o_valid | i_ready;
  assign accept  = i_valid & o_ready;
  assign any_oor = |lane_oor;

  // Per-lane select: only codes below GRP pick an element; every other code yields zero.
  // The compare-per-element form keeps the index inside the lane's own group.
  always_comb begin
    lane_data = '0;
    lane_oor  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      lane_oor[k] = (sel_q[k*SEL_W +: SEL_W] >= GRP_SEL);
      for (int g = 0; g < GRP; g++) begin
        if (sel_q[k*SEL_W +: SEL_W] == SEL_W'(g)) begin
          lane_data[k*W +: W] = i_data[(k*GRP+g)*W +: W];
        end
      end
    end
  end

  // Active select register; a beat accepted on the load edge still sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= '0;
    end else if (i_cfg_valid) begin
      sel_q <= i_cfg_sel;
    end
  end

  // Output register: load on accept, drop valid on drain, otherwise hold data and valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_data  <= lane_data;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Saturating count of accepted beats with any out-of-range lane; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_oor_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_oor_cnt <= '0;
    end else if (accept && any_oor && (o_oor_cnt != CNT_MAX)) begin
      o_oor_cnt <= o_oor_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_reduction_mux_pipe.sv
// tb/tb_reduction_mux_pipe.sv - self-checking bench for reduction_mux_pipe
module tb_reduction_mux_pipe;
  localparam int W       = 32;
  localparam int NUM_IN  = 8;
  localparam int NUM_OUT = 2;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 2;
  localparam int GRP     = NUM_IN / NUM_OUT;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     i_cfg_valid;
  logic [NUM_OUT*SEL_W-1:0] i_cfg_sel;
  logic                     i_valid;
  logic                     o_ready;
  logic [NUM_IN*W-1:0]      i_data;
  logic                     o_valid;
  logic                     i_ready;
  logic [NUM_OUT*W-1:0]     o_data;
  logic                     i_clr_cnt;
  logic [CNT_W-1:0]         o_oor_cnt;

  int total = 0;
  int bad   = 0;

  bit          m_valid;
  logic [31:0] m_data [NUM_OUT];
  int          m_sel  [NUM_OUT];
  int          m_cnt;

  typedef struct {
    int          s0;
    int          s1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t tbl [6];

  logic [63:0] held;

  reduction_mux_pipe #(
    .W(W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cfg_valid(i_cfg_valid), .i_cfg_sel(i_cfg_sel),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .i_clr_cnt(i_clr_cnt), .o_oor_cnt(o_oor_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] elem(input int j);
    return i_data[j*W +: W];
  endfunction

  task automatic set_data(input logic [31:0] base);
    for (int j = 0; j < NUM_IN; j++) i_data[j*W +: W] = base + 32'(j);
  endtask

  task automatic set_sel(input int s0, input int s1);
    i_cfg_sel = {3'(s1), 3'(s0)};
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_cnt   = 0;
    for (int k = 0; k < NUM_OUT; k++) begin
      m_data[k] = '0;
      m_sel[k]  = 0;
    end
  endtask

  // One clock: predict from the driven inputs, advance, compare registered outputs.
  task automatic cycle();
    bit rdy, acc, oor;
    #1;
    rdy = !m_valid || i_ready;
    chk("o_ready", {63'd0, o_ready}, {63'd0, rdy});
    acc = i_valid && rdy;
    oor = 0;
    if (acc) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (m_sel[k] < GRP) m_data[k] = elem(k*GRP + m_sel[k]);
        else begin
          m_data[k] = 32'd0;
          oor = 1;
        end
      end
      m_valid = 1;
    end else if (i_ready) begin
      m_valid = 0;
    end
    if (i_clr_cnt) m_cnt = 0;
    else if (acc && oor && m_cnt < CNT_TOP) m_cnt++;
    if (i_cfg_valid)
      for (int k = 0; k < NUM_OUT; k++) m_sel[k] = int'(i_cfg_sel[k*SEL_W +: SEL_W]);
    @(posedge clk);
    #1;
    chk("o_valid", {63'd0, o_valid}, {63'd0, m_valid});
    chk("o_data", o_data, {m_data[1], m_data[0]});
    chk("o_oor_cnt", {62'd0, o_oor_cnt}, 64'(m_cnt));
  endtask

  task automatic load_cfg(input int s0, input int s1);
    i_valid = 0;
    set_sel(s0, s1);
    i_cfg_valid = 1;
    cycle();
    i_cfg_valid = 0;
  endtask

  initial begin
    tbl[0] = '{0, 0, 32'h100, 32'h104};
    tbl[1] = '{1, 2, 32'h101, 32'h106};
    tbl[2] = '{3, 3, 32'h103, 32'h107};
    tbl[3] = '{4, 0, 32'h000, 32'h104};
    tbl[4] = '{2, 5, 32'h102, 32'h000};
    tbl[5] = '{7, 7, 32'h000, 32'h000};

    rst = 0; i_cfg_valid = 0; i_cfg_sel = '0; i_valid = 0; i_ready = 1;
    i_data = '0; i_clr_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_o_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_o_data", o_data, 64'd0);
    chk("reset_o_oor_cnt", {62'd0, o_oor_cnt}, 64'd0);
    chk("reset_o_ready", {63'd0, o_ready}, 64'd1);
    rst = 1;

    // Table: each row loads a select pair then sends one beat with elem j = 0x100+j.
    set_data(32'h100);
    for (int r = 0; r < 6; r++) begin
      load_cfg(tbl[r].s0, tbl[r].s1);
      i_valid = 1;
      cycle();
      i_valid = 0;
      chk($sformatf("tbl%0d_lane0", r), {32'd0, o_data[31:0]}, {32'd0, tbl[r].e0});
      chk($sformatf("tbl%0d_lane1", r), {32'd0, o_data[63:32]}, {32'd0, tbl[r].e1});
    end

    // Out-of-range codes (== GRP and max), three beats, then clear racing a fourth beat.
    i_clr_cnt = 1; cycle(); i_clr_cnt = 0;
    load_cfg(4, 7);
    i_valid = 1;
    for (int b = 0; b < 3; b++) begin
      set_data(32'h500 + 32'(b*16));
      cycle();
      chk("oor_lanes_zero", o_data, 64'd0);
    end
    chk("oor_cnt_3", {62'd0, o_oor_cnt}, 64'd3);
    i_clr_cnt = 1;
    cycle();
    i_clr_cnt = 0;
    chk("oor_clear_wins", {62'd0, o_oor_cnt}, 64'd0);

    // Saturation: five more out-of-range beats stick at the counter maximum.
    for (int b = 0; b < 5; b++) cycle();
    chk("oor_saturate", {62'd0, o_oor_cnt}, 64'(CNT_TOP));
    i_valid = 0;
    cycle();

    // Backpressure: held beat must not move while data and config keep changing.
    load_cfg(1, 2);
    set_data(32'h700);
    i_valid = 1;
    cycle();
    held = o_data;
    chk("bp_first_beat", held, {32'h706, 32'h701});
    i_ready = 0;
    for (int c = 0; c < 5; c++) begin
      i_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      set_sel(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      i_cfg_valid = 1;
      cycle();
      chk("bp_hold", o_data, held);
    end
    i_cfg_valid = 0;
    i_ready = 1;
    for (int c = 0; c < 4; c++) begin
      set_data(32'h800 + 32'(c*16));
      cycle();
    end
    i_valid = 0;
    cycle();

    // Config race: select change on the edge that accepts beat A applies only to beat B.
    load_cfg(0, 0);
    set_data(32'h100);
    set_sel(3, 0);
    i_cfg_valid = 1;
    i_valid = 1;
    cycle();
    i_cfg_valid = 0;
    chk("race_beat_a", {32'd0, o_data[31:0]}, 64'h100);
    set_data(32'h200);
    cycle();
    chk("race_beat_b", {32'd0, o_data[31:0]}, 64'h203);
    i_valid = 0;

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      i_valid     = ($urandom_range(0, 3) != 0);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_cfg_valid = ($urandom_range(0, 7) == 0);
      i_clr_cnt   = ($urandom_range(0, 15) == 0);
      i_cfg_sel   = 6'($urandom);
      i_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    i_cfg_valid = 0; i_clr_cnt = 0;

    // Async reset between edges while a beat is held, then a beat under default selects.
    load_cfg(2, 1);
    set_data(32'h900);
    i_valid = 1; i_ready = 0;
    cycle();
    chk("prereset_valid", {63'd0, o_valid}, 64'd1);
    i_valid = 0;
    #2;
    rst = 0;
    #1;
    chk("async_rst_valid", {63'd0, o_valid}, 64'd0);
    chk("async_rst_data", o_data, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    i_ready = 1;
    set_data(32'h300);
    i_valid = 1;
    cycle();
    i_valid = 0;
    chk("post_rst_lane0", {32'd0, o_data[31:0]}, 64'h300);
    chk("post_rst_lane1", {32'd0, o_data[63:32]}, 64'h304);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
